// File: rtl/tt_um_richard28277.sv
// tt_um_richard28277 -- registered 4-bit ALU inside the Tiny Tapeout shell.
// Operand a = ui_in[3:0], operand b = ui_in[7:4], opcode = uio_in[3:0].
// One of 16 operations is evaluated combinationally each cycle and the
// 8-bit result plus four status flags are captured when ena is high.
// uio[7:4] carry the flags outward; uio[3:0] stay inputs for the opcode.

module tt_um_richard28277 (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  // Opcode map.
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_MUL    = 4'h2;
  localparam logic [3:0] OP_DIV    = 4'h3;
  localparam logic [3:0] OP_AND    = 4'h4;
  localparam logic [3:0] OP_OR     = 4'h5;
  localparam logic [3:0] OP_XOR    = 4'h6;
  localparam logic [3:0] OP_NOT    = 4'h7;
  localparam logic [3:0] OP_NAND   = 4'h8;
  localparam logic [3:0] OP_NOR    = 4'h9;
  localparam logic [3:0] OP_XNOR   = 4'hA;
  localparam logic [3:0] OP_SHL    = 4'hB;
  localparam logic [3:0] OP_SHR    = 4'hC;
  localparam logic [3:0] OP_CMP    = 4'hD;
  localparam logic [3:0] OP_MAXMIN = 4'hE;
  localparam logic [3:0] OP_SWAP   = 4'hF;

  // Flag vector layout inside the flag register: {dz, borrow, carry, zero}.
  localparam int FLAG_ZERO   = 0;
  localparam int FLAG_CARRY  = 1;
  localparam int FLAG_BORROW = 2;
  localparam int FLAG_DZ     = 3;

  // Status flags derived from the same operands/opcode as the result.
  // carry looks at the 5-bit sum so it is independent of the 8-bit result.
  function automatic logic [3:0] flags_f(
    input logic [3:0] op,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [7:0] res
  );
    logic [3:0] f;
    logic [4:0] sum5;
    f    = 4'h0;
    sum5 = {1'b0, a} + {1'b0, b};
    f[FLAG_ZERO]   = (res == 8'h00);
    f[FLAG_CARRY]  = (op == OP_ADD) && (sum5 > 5'd15);
    f[FLAG_BORROW] = (op == OP_SUB) && (a < b);
    f[FLAG_DZ]     = (op == OP_DIV) && (b == 4'h0);
    return f;
  endfunction

  // Field extraction.
  logic [3:0] a_s;
  logic [3:0] b_s;
  logic [3:0] op_s;
  logic [7:0] a8_s;
  logic [7:0] b8_s;

  assign a_s  = ui_in[3:0];
  assign b_s  = ui_in[7:4];
  assign op_s = uio_in[3:0];
  assign a8_s = {4'h0, a_s};
  assign b8_s = {4'h0, b_s};

  // uio_in[7:4] are outputs on the pad side; their input values are ignored.
  logic unused_uio_bits;
  assign unused_uio_bits = &{1'b0, uio_in[7:4]};

  // Divider outputs (only meaningful when b is non-zero).
  logic [7:0] quot_s;
  logic [7:0] rem_s;

  // Combinational divider; guarded so a zero divisor never reaches the operator.
  always_comb begin
    quot_s = 8'h00;
    rem_s  = 8'h00;
    if (b_s != 4'h0) begin
      quot_s = a8_s / b8_s;
      rem_s  = a8_s % b8_s;
    end else begin
      quot_s = 8'h00;
      rem_s  = 8'h00;
    end
  end

  // Next result / flags.
  logic [7:0] result_d;
  logic [3:0] flags_d;

  // Result multiplexer: one operation per opcode, all results mod 256.
  always_comb begin
    result_d = 8'h00;
    case (op_s)
      OP_ADD:  result_d = a8_s + b8_s;
      OP_SUB:  result_d = a8_s - b8_s;
      OP_MUL:  result_d = a8_s * b8_s;
      OP_DIV: begin
        if (b_s == 4'h0) begin
          result_d = {a_s, 4'hF};
        end else begin
          result_d = {rem_s[3:0], quot_s[3:0]};
        end
      end
      OP_AND:  result_d = {4'h0, a_s & b_s};
      OP_OR:   result_d = {4'h0, a_s | b_s};
      OP_XOR:  result_d = {4'h0, a_s ^ b_s};
      OP_NOT:  result_d = {4'h0, ~a_s};
      OP_NAND: result_d = {4'h0, ~(a_s & b_s)};
      OP_NOR:  result_d = {4'h0, ~(a_s | b_s)};
      OP_XNOR: result_d = {4'h0, ~(a_s ^ b_s)};
      OP_SHL:  result_d = a8_s << b_s[1:0];
      OP_SHR:  result_d = {4'h0, a_s >> b_s[1:0]};
      OP_CMP:  result_d = {5'b00000, (a_s > b_s), (a_s == b_s), (a_s < b_s)};
      OP_MAXMIN: begin
        if (a_s >= b_s) begin
          result_d = {a_s, b_s};
        end else begin
          result_d = {b_s, a_s};
        end
      end
      OP_SWAP: result_d = {a_s, b_s};
      default: result_d = 8'h00;
    endcase
  end

  // Flags follow the freshly computed result.
  always_comb begin
    flags_d = 4'h0;
    flags_d = flags_f(op_s, a_s, b_s, result_d);
  end

  // Result and flag registers.
  logic [7:0] result_q;
  logic [3:0] flags_q;

  // Capture result/flags when selected; hold otherwise; async clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 8'h00;
      flags_q  <= 4'h0;
    end else if (ena) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end else begin
      result_q <= result_q;
      flags_q  <= flags_q;
    end
  end

  assign uo_out  = result_q;
  assign uio_out = {flags_q, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_richard28277.sv
// Self-checking bench for tt_um_richard28277: directed test-plan vectors
// with literal expectations, then randomized traffic against a reference
// model computed with plain integer arithmetic.

module tb_tt_um_richard28277;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_pass   = 0;

  tt_um_richard28277 dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  // Reference: returns {uio_out, uo_out} from integer arithmetic on a, b, op.
  function automatic logic [15:0] ref_alu(input int a, input int b, input int op);
    int r;
    int zero, carry, borrow, dz;
    int mx, mn;
    case (op)
      0:  r = a + b;
      1:  r = (a - b + 256) % 256;
      2:  r = a * b;
      3:  r = (b == 0) ? (a * 16 + 15) : ((a % b) * 16 + (a / b));
      4:  r = a & b;
      5:  r = a | b;
      6:  r = a ^ b;
      7:  r = 15 - a;
      8:  r = 15 - (a & b);
      9:  r = 15 - (a | b);
      10: r = 15 - (a ^ b);
      11: r = a * (1 << (b % 4));
      12: r = a / (1 << (b % 4));
      13: r = (a > b) ? 4 : ((a == b) ? 2 : 1);
      14: begin
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        r  = mx * 16 + mn;
      end
      default: r = a * 16 + b;
    endcase
    r      = r % 256;
    zero   = (r == 0) ? 1 : 0;
    carry  = (op == 0 && a + b > 15) ? 1 : 0;
    borrow = (op == 1 && a < b) ? 1 : 0;
    dz     = (op == 3 && b == 0) ? 1 : 0;
    return 16'((zero * 16 + carry * 32 + borrow * 64 + dz * 128) * 256 + r);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: what the outputs must show after the latest edge.
  logic [7:0] exp_uo  = 8'h00;
  logic [7:0] exp_uio = 8'h00;

  // Reference register update from the model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_uo  <= 8'h00;
      exp_uio <= 8'h00;
    end else if (ena) begin
      exp_uo  <= ref_alu(int'(ui_in[3:0]), int'(ui_in[7:4]), int'(uio_in[3:0])) >> 0;
      exp_uio <= 8'(ref_alu(int'(ui_in[3:0]), int'(ui_in[7:4]), int'(uio_in[3:0])) >> 8);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_uo_out", uo_out, exp_uo);
    check("model_uio_out", uio_out, exp_uio);
    check("uio_oe", uio_oe, 8'hF0);
  end

  // Apply one operation at the falling edge, return after the next rising edge.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    @(negedge clk);
    ui_in  = {b, a};
    uio_in = {4'($urandom_range(0, 15)), op};
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] lit_res [7];
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'h02;

    // Reset held with clock running.
    repeat (3) @(posedge clk);
    #1;
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h00);
    check("reset_oe", uio_oe, 8'hF0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_mul", uo_out, 8'hE1);
    check("release_flags", uio_out, 8'h00);

    apply(4'h9, 4'h8, 4'h0);
    check("add_9_8", uo_out, 8'h11);
    check("add_9_8_flags", uio_out, 8'h20);
    apply(4'h0, 4'h0, 4'h0);
    check("add_0_0", uo_out, 8'h00);
    check("add_0_0_flags", uio_out, 8'h10);

    apply(4'h3, 4'h5, 4'h1);
    check("sub_3_5", uo_out, 8'hFE);
    check("sub_flags", uio_out, 8'h40);
    apply(4'hF, 4'hF, 4'h2);
    check("mul_f_f", uo_out, 8'hE1);
    check("mul_flags", uio_out, 8'h00);

    apply(4'hD, 4'h4, 4'h3);
    check("div_13_4", uo_out, 8'h13);
    check("div_flags", uio_out, 8'h00);
    apply(4'h7, 4'h0, 4'h3);
    check("div_by_zero", uo_out, 8'h7F);
    check("div_by_zero_flags", uio_out, 8'h80);

    lit_res = '{8'h02, 8'h0E, 8'h0C, 8'h05, 8'h0D, 8'h01, 8'h03};
    for (int i = 0; i < 7; i++) begin
      apply(4'hA, 4'h6, 4'(4 + i));
      check($sformatf("logic_op%0d", 4 + i), uo_out, lit_res[i]);
    end

    apply(4'hF, 4'h3, 4'hB);
    check("shl", uo_out, 8'h78);
    apply(4'hF, 4'h3, 4'hC);
    check("shr", uo_out, 8'h01);

    apply(4'h5, 4'h9, 4'hD);
    check("cmp", uo_out, 8'h01);
    apply(4'h5, 4'h9, 4'hE);
    check("maxmin", uo_out, 8'h95);
    apply(4'h5, 4'h9, 4'hF);
    check("swap", uo_out, 8'h59);

    // Hold with ena low while inputs change.
    @(negedge clk);
    ena = 1'b0;
    apply(4'h1, 4'h2, 4'h0);
    apply(4'h7, 4'h0, 4'h3);
    check("ena_hold", uo_out, 8'h59);
    check("ena_hold_flags", uio_out, 8'h00);
    @(negedge clk);
    ena = 1'b1;

    // Async reset mid-stream clears without a clock edge.
    apply(4'h7, 4'h0, 4'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_uo", uo_out, 8'h00);
    check("async_reset_uio", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ui_in  = 8'($urandom_range(0, 255));
      uio_in = 8'($urandom_range(0, 255));
      ena    = ($urandom_range(0, 7) != 0);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tt_um_richard28277.md
# tt_um_richard28277

Registered 4-bit ALU wrapped in the standard Tiny Tapeout user-project shell. Two 4-bit operands arrive on `ui_in`, a 4-bit opcode on `uio_in[3:0]`. One of 16 arithmetic, logic, shift or compare operations is computed combinationally and captured into an 8-bit result register driven on `uo_out`. Status flags are registered alongside the result and driven on `uio_out[7:4]`.

## Interface
- No parameters.
- `clk` input 1: single clock; all state is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ena` input 1: high when the design is selected; result/flag registers update only when it is 1.
- `ui_in` input 8: `ui_in[3:0]` = operand a, `ui_in[7:4]` = operand b; both unsigned.
- `uio_in` input 8: `uio_in[3:0]` = opcode; `uio_in[7:4]` are ignored.
- `uo_out` output 8: registered result.
- `uio_out` output 8: `[3:0]` = 0; `[4]` zero; `[5]` carry; `[6]` borrow; `[7]` divide-by-zero. All are registered.
- `uio_oe` output 8: constant `8'hF0`, so `uio[7:4]` are outputs and `uio[3:0]` are inputs.
- Power pins `VPWR`/`VGND` exist only in gate-level netlists; RTL has none.

## Operation
- Operands a and b are zero-extended to 8 bits. All results are mod 256.
- Opcode to next result:
  - `0` ADD: a+b (0..30).
  - `1` SUB: (a−b) mod 256, e.g. 3−5 = 0xFE.
  - `2` MUL: a*b (0..225).
  - `3` DIV: {a%b, a/b}, remainder in the high nibble and quotient in the low nibble.
    - If b=0, the result is {a, 4'hF}.
  - `4` AND: {4'h0, a&b}.
  - `5` OR: {4'h0, a|b}.
  - `6` XOR: {4'h0, a^b}.
  - `7` NOT: {4'h0, ~a}.
  - `8` NAND: {4'h0, ~(a&b)}.
  - `9` NOR: {4'h0, ~(a|b)}.
  - `A` XNOR: {4'h0, ~(a^b)}.
  - `B` SHL: a << b[1:0], 8-bit result (no loss).
  - `C` SHR: {4'h0, a >> b[1:0]}.
  - `D` CMP: {5'b0, a>b, a==b, a<b}.
  - `E` MAXMIN: {max(a,b), min(a,b)}.
  - `F` SWAP: {a, b}.
- Flags are computed from the same inputs as the result:
  - zero = (next result == 0), for every opcode.
  - carry = opcode 0 and a+b > 15.
  - borrow = opcode 1 and a < b.
  - dz = opcode 3 and b == 0.
  - Each of carry, borrow and dz is 0 for all other opcodes.
- The datapath is purely combinational into one 8-bit result register and one 4-bit flag register. There is no FSM and no multi-cycle operation; the divider is combinational.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `uo_out` = 0x00.
  - `uio_out` = 0x00 (all flags 0, including zero).
  - `uio_oe` = 0xF0 at all times, including during reset.
- Latency is 1 cycle. Inputs and opcode sampled at rising edge N appear on `uo_out`/`uio_out` after edge N.
- Throughput is one operation per cycle. The opcode and operands may change every cycle.
- `ena`=0 leaves the registers holding their value. `ena`=1 loads them every cycle.
- Reset deasserting mid-stream: the first edge after release loads the current inputs normally.
- Reset asserting mid-stream: outputs clear immediately, with no clock edge needed.

## Test plan
- Reset: hold `rst_n`=0 with a=F, b=F, opcode=2 and clock running -> `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0xF0. Release -> next edge gives `uo_out`=0xE1.
- ADD: a=9, b=8, op=0 -> `uo_out`=0x11, carry=1, zero=0. Then a=0, b=0 -> 0x00, zero=1, carry=0.
- SUB/MUL: a=3, b=5, op=1 -> 0xFE, borrow=1. Then a=F, b=F, op=2 -> 0xE1, flags 0.
- DIV: a=13, b=4, op=3 -> 0x13, dz=0. Then a=7, b=0, op=3 -> 0x7F, dz=1.
- Logic/shift: a=0xA, b=0x6, ops 4..A -> 0x02, 0x0E, 0x0C, 0x05, 0x0D, 0x01, 0x03. Then a=0xF, b=3, op=B -> 0x78; op=C -> 0x01.
- Compare/ena:
  - a=5, b=9: op=D -> 0x01; op=E -> 0x95; op=F -> 0x59.
  - Drop `ena` to 0 and change the inputs -> `uo_out` holds 0x59.
